class_hv_accumulator: RTL and testbench

Builds the non-binary class hypervectors by bundling binary encoded hypervectors into saturating per-dimension counters, one DIMS_PER_CC-wide chunk per cycle. It then streams the finished counter chunks to the class thresholder for binarization. It is the writer/producer end of the non-binary class register path. It sits between the encoder output stream and the thresholder input `nonbin_class_reg_out`, and holds one class's counters, NUM_CHUNKS chunks deep.

---
 rtl/class_hv_accumulator_if.sv | 37 +++
 rtl/class_hv_accumulator.sv | 172 +++++++++++++++++
 tb/tb_class_hv_accumulator.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/class_hv_accumulator_if.sv
// Handshake bundle between the encoder/thresholder side and the class
// hypervector accumulator. master = control/stream driver, slave = accumulator.
interface class_hv_accumulator_if #(
    parameter int DIMS_PER_CC      = 32,
    parameter int BITWIDTH_PER_DIM = 8,
    parameter int NUM_CHUNKS       = 16
);
    localparam int PTR_W = $clog2(NUM_CHUNKS);

    logic                                             clear_start;
    logic                                             readout_start;
    logic                                             in_valid;
    logic                                             in_ready;
    logic                                             in_sub;
    logic [DIMS_PER_CC-1:0]                           in_hv;
    logic                                             out_valid;
    logic                                             out_ready;
    logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0]     out_data;
    logic [PTR_W-1:0]                                 out_idx;
    logic                                             out_last;
    logic                                             busy;
    logic                                             hv_done;
    logic [15:0]                                      hv_count;
    logic                                             cmd_err;

    modport master (
        output clear_start, readout_start, in_valid, in_sub, in_hv, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last,
               busy, hv_done, hv_count, cmd_err
    );

    modport slave (
        input  clear_start, readout_start, in_valid, in_sub, in_hv, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last,
               busy, hv_done, hv_count, cmd_err
    );
endinterface

// File: rtl/class_hv_accumulator.sv
// Class hypervector accumulator: bundles binary HV chunks into saturating
// per-dimension counters and streams the finished counters out chunk by chunk.

// One dimension's counter column: NUM_CHUNKS saturating counters.
module class_hv_lane #(
    parameter int BITWIDTH_PER_DIM = 8,
    parameter int NUM_CHUNKS       = 16,
    parameter int PTR_W            = 4
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        wr_en,
    input  logic                        sub,
    input  logic                        hv_bit,
    input  logic                        clr_en,
    input  logic [PTR_W-1:0]            wr_ptr,
    input  logic [PTR_W-1:0]            rd_ptr,
    output logic [BITWIDTH_PER_DIM-1:0] rd_data
);
    localparam logic [BITWIDTH_PER_DIM-1:0] CNT_MAX = '1;
    localparam logic [BITWIDTH_PER_DIM-1:0] CNT_ONE = BITWIDTH_PER_DIM'(1);

    logic [BITWIDTH_PER_DIM-1:0] bank [NUM_CHUNKS];
    logic [BITWIDTH_PER_DIM-1:0] cur, nxt;

    // Saturating +/-1 of the addressed counter; a zero bit leaves it alone.
    always_comb begin
        cur = bank[wr_ptr];
        nxt = cur;
        if (hv_bit) begin
            if (sub) nxt = (cur == '0) ? cur : cur - CNT_ONE;
            else     nxt = (cur == CNT_MAX) ? cur : cur + CNT_ONE;
        end
    end

    // Counter storage; clear sweep and beat writes never overlap (different states).
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CHUNKS; c++) bank[c] <= '0;
        end else if (clr_en) begin
            bank[rd_ptr] <= '0;
        end else if (wr_en) begin
            bank[wr_ptr] <= nxt;
        end
    end

    assign rd_data = bank[rd_ptr];
endmodule

module class_hv_accumulator #(
    parameter int DIMS_PER_CC      = 32,
    parameter int BITWIDTH_PER_DIM = 8,
    parameter int NUM_CHUNKS       = 16
) (
    input logic                    clk,
    input logic                    nrst,
    class_hv_accumulator_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_CHUNKS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CHUNKS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, CLEAR, READOUT} state_t;

    state_t                                       state, state_nxt;
    logic [PTR_W-1:0]                             wr_ptr, rd_ptr;
    logic [15:0]                                  hv_count;
    logic                                         hv_done_q, cmd_err_q;
    logic                                         clear_go, rdo_go, rdo_rej;
    logic                                         in_ready_c, beat, last_rd;
    logic                                         clr_active;
    logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0] lane_data;

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and command decode; clear beats readout beats input beat.
    always_comb begin
        state_nxt = state;
        clear_go  = 1'b0;
        rdo_go    = 1'b0;
        rdo_rej   = 1'b0;
        last_rd   = (rd_ptr == LAST_IDX);
        case (state)
            IDLE: begin
                if (bus.clear_start) begin
                    clear_go  = 1'b1;
                    state_nxt = CLEAR;
                end else if (bus.readout_start) begin
                    // Readout of a half-written HV would stream a torn vector.
                    if (wr_ptr == '0) begin
                        rdo_go    = 1'b1;
                        state_nxt = READOUT;
                    end else begin
                        rdo_rej   = 1'b1;
                    end
                end
            end
            CLEAR:   if (last_rd) state_nxt = IDLE;
            READOUT: if (bus.out_ready && last_rd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        in_ready_c = (state == IDLE) && !clear_go && !rdo_go;
        beat       = bus.in_valid && in_ready_c;
    end

    // Pointers, HV counter and the registered status pulses.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hv_count  <= '0;
            hv_done_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            hv_done_q <= beat && (wr_ptr == LAST_IDX);
            cmd_err_q <= rdo_rej;
            case (state)
                IDLE: begin
                    if (clear_go) begin
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        hv_count <= '0;
                    end else if (rdo_go) begin
                        rd_ptr   <= '0;
                    end else if (beat) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        if (wr_ptr == LAST_IDX && hv_count != 16'hFFFF)
                            hv_count <= hv_count + 16'd1;
                    end
                end
                // rd_ptr wraps to 0 on the last chunk, leaving it ready for IDLE.
                CLEAR:   rd_ptr <= rd_ptr + PTR_ONE;
                READOUT: if (bus.out_ready) rd_ptr <= rd_ptr + PTR_ONE;
                default: rd_ptr <= '0;
            endcase
        end
    end

    assign clr_active = (state == CLEAR);

    for (genvar g = 0; g < DIMS_PER_CC; g++) begin : g_lane
        class_hv_lane #(
            .BITWIDTH_PER_DIM (BITWIDTH_PER_DIM),
            .NUM_CHUNKS       (NUM_CHUNKS),
            .PTR_W            (PTR_W)
        ) u_lane (
            .clk     (clk),
            .nrst    (nrst),
            .wr_en   (beat),
            .sub     (bus.in_sub),
            .hv_bit  (bus.in_hv[g]),
            .clr_en  (clr_active),
            .wr_ptr  (wr_ptr),
            .rd_ptr  (rd_ptr),
            .rd_data (lane_data[g])
        );
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == READOUT);
    assign bus.out_data  = bus.out_valid ? lane_data : '0;
    assign bus.out_idx   = bus.out_valid ? rd_ptr : '0;
    assign bus.out_last  = bus.out_valid && last_rd;
    assign bus.busy      = (state != IDLE);
    assign bus.hv_done   = hv_done_q;
    assign bus.hv_count  = hv_count;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_class_hv_accumulator.sv
// Self-checking bench for class_hv_accumulator: random and directed HV streams
// checked against an integer counter-array model of the bundling rules.
module tb_class_hv_accumulator;
    localparam int DIMS = 32;
    localparam int BW   = 8;
    localparam int NCH  = 16;
    localparam int PW   = 4;
    localparam int CMAX = 255;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    class_hv_accumulator_if #(.DIMS_PER_CC(DIMS), .BITWIDTH_PER_DIM(BW), .NUM_CHUNKS(NCH)) bus();

    class_hv_accumulator #(.DIMS_PER_CC(DIMS), .BITWIDTH_PER_DIM(BW), .NUM_CHUNKS(NCH)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer counters per chunk/dimension.
    int model [NCH][DIMS];
    int m_wr, m_hv, exp_done;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Readout capture.
    logic [DIMS-1:0][BW-1:0] cap_data [NCH];
    logic cap_last [NCH];
    int   cap_n;
    bit   cap_idx_bad, cap_hold_bad, cap_rdy_bad, cap_end_valid;

    always @(negedge clk) begin
        if (bus.hv_done) done_cnt <= done_cnt + 1;
        if (bus.cmd_err) err_cnt  <= err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int d = 0; d < DIMS; d++) model[c][d] = 0;
        m_wr = 0;
        m_hv = 0;
    endtask

    task automatic model_beat(input logic [DIMS-1:0] hv, input bit sub);
        for (int d = 0; d < DIMS; d++)
            if (hv[d]) begin
                if (sub) model[m_wr][d] = (model[m_wr][d] > 0) ? model[m_wr][d] - 1 : 0;
                else     model[m_wr][d] = (model[m_wr][d] < CMAX) ? model[m_wr][d] + 1 : CMAX;
            end
        m_wr = (m_wr + 1) % NCH;
        if (m_wr == 0) begin
            exp_done++;
            if (m_hv < 65535) m_hv++;
        end
    endtask

    task automatic do_reset();
        nrst              = 1'b0;
        bus.clear_start   = 1'b0;
        bus.readout_start = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_sub        = 1'b0;
        bus.in_hv         = '0;
        bus.out_ready     = 1'b0;
        tick();
        nrst = 1'b1;
        model_reset();
    endtask

    task automatic send_beat(input logic [DIMS-1:0] hv, input bit sub);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_hv    = hv;
        bus.in_sub   = sub;
        #1;
        acc = bus.in_ready;
        tick();
        bus.in_valid = 1'b0;
        if (acc) model_beat(hv, sub);
    endtask

    task automatic send_hv(input logic [DIMS-1:0] hv, input bit sub, input int times);
        for (int t = 0; t < times; t++)
            for (int c = 0; c < NCH; c++) send_beat(hv, sub);
    endtask

    // mode 0: out_ready=1, mode 1: 1,0,0 repeating, mode 2: random.
    task automatic readout(input int mode);
        logic [DIMS-1:0][BW-1:0] prev_data;
        bit have_prev, r;
        bus.readout_start = 1'b1;
        tick();
        bus.readout_start = 1'b0;
        cap_n = 0; cap_idx_bad = 0; cap_hold_bad = 0; cap_rdy_bad = 0; have_prev = 0;
        prev_data = '0;
        for (int cyc = 0; cyc < 200 && cap_n < NCH; cyc++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = r;
            #1;
            if (!bus.out_valid) break;
            if (bus.in_ready) cap_rdy_bad = 1;
            if (bus.out_idx !== PW'(cap_n)) cap_idx_bad = 1;
            if (have_prev && bus.out_data !== prev_data) cap_hold_bad = 1;
            if (r) begin
                cap_data[cap_n] = bus.out_data;
                cap_last[cap_n] = bus.out_last;
                cap_n++;
                have_prev = 0;
            end else begin
                if (bus.out_last !== (cap_n == NCH - 1)) cap_idx_bad = 1;
                prev_data = bus.out_data;
                have_prev = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        cap_end_valid = bus.out_valid;
    endtask

    function automatic int model_diff();
        int n = 0;
        for (int c = 0; c < NCH; c++)
            for (int d = 0; d < DIMS; d++)
                if (cap_data[c][d] !== BW'(model[c][d])) n++;
        return n;
    endfunction

    function automatic int last_bad();
        int n = 0;
        for (int c = 0; c < NCH; c++)
            if (cap_last[c] !== (c == NCH - 1)) n++;
        return n;
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: busy=%b out_valid=%b, required 0 0", bus.busy, bus.out_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        n_checks++;
        if (bus.hv_count !== 16'd0 || bus.hv_done !== 1'b0 || bus.cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_counts: hv_count=%0d hv_done=%b cmd_err=%b, required 0 0 0",
                               bus.hv_count, bus.hv_done, bus.cmd_err);
        end
        n_checks++;
        if (bus.out_data !== '0 || bus.out_idx !== '0 || bus.out_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: out_data=%h out_idx=%0d, required 0 0", bus.out_data, bus.out_idx);
        end
    endtask

    task automatic test_bundle_ones();
        int d0, e0;
        do_reset();
        d0 = done_cnt; e0 = exp_done;
        send_hv('1, 1'b0, 3);
        n_checks++;
        if (bus.hv_count !== 16'd3) begin
            n_fail++; $display("FAIL bundle3_hv_count: got %0d, required 3", bus.hv_count);
        end
        readout(0);
        n_checks++;
        if (done_cnt - d0 != 3 || exp_done - e0 != 3) begin
            n_fail++; $display("FAIL bundle3_hv_done: got %0d pulses, required 3", done_cnt - d0);
        end
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || cap_data[7][4] !== 8'd3) begin
            n_fail++; $display("FAIL bundle3_data: beats=%0d bad_dims=%0d c7d4=%0d, required 16 0 3",
                               cap_n, model_diff(), cap_data[7][4]);
        end
        n_checks++;
        if (last_bad() != 0 || cap_idx_bad || cap_end_valid) begin
            n_fail++; $display("FAIL bundle3_last_idx: bad_last=%0d idx_bad=%b end_valid=%b, required 0 0 0",
                               last_bad(), cap_idx_bad, cap_end_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        send_hv('1, 1'b0, 300);
        readout(0);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || cap_data[15][31] !== 8'd255) begin
            n_fail++; $display("FAIL sat_high: beats=%0d bad_dims=%0d c15d31=%0d, required 16 0 255",
                               cap_n, model_diff(), cap_data[15][31]);
        end
        n_checks++;
        if (bus.hv_count !== 16'd300) begin
            n_fail++; $display("FAIL sat_hv_count: got %0d, required 300", bus.hv_count);
        end
        send_hv('1, 1'b1, 1);
        readout(2);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || cap_data[0][0] !== 8'd254) begin
            n_fail++; $display("FAIL sat_sub: beats=%0d bad_dims=%0d c0d0=%0d, required 16 0 254",
                               cap_n, model_diff(), cap_data[0][0]);
        end
        do_reset();
        send_hv('1, 1'b1, 1);
        readout(0);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || cap_data[3][9] !== 8'd0) begin
            n_fail++; $display("FAIL sat_low: beats=%0d bad_dims=%0d c3d9=%0d, required 16 0 0",
                               cap_n, model_diff(), cap_data[3][9]);
        end
    endtask

    task automatic test_alternating();
        do_reset();
        send_hv(32'hAAAAAAAA, 1'b0, 5);
        send_hv(32'h55555555, 1'b0, 2);
        readout(0);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0) begin
            n_fail++; $display("FAIL alt_data: beats=%0d bad_dims=%0d, required 16 0", cap_n, model_diff());
        end
        n_checks++;
        if (cap_data[9][1] !== 8'd5 || cap_data[9][0] !== 8'd2) begin
            n_fail++; $display("FAIL alt_dims: odd=%0d even=%0d, required 5 2", cap_data[9][1], cap_data[9][0]);
        end
    endtask

    task automatic test_readout_reject();
        logic [DIMS-1:0] hv;
        bit acc;
        int e0;
        do_reset();
        for (int b = 0; b < 7; b++) send_beat(DIMS'($urandom), 1'b0);
        e0 = err_cnt;
        hv = DIMS'($urandom);
        bus.readout_start = 1'b1;
        bus.in_valid      = 1'b1;
        bus.in_hv         = hv;
        bus.in_sub        = 1'b0;
        #1;
        acc = bus.in_ready;
        n_checks++;
        if (acc !== 1'b1) begin
            n_fail++; $display("FAIL reject_in_ready: got %b, required 1", acc);
        end
        tick();
        bus.readout_start = 1'b0;
        bus.in_valid      = 1'b0;
        if (acc) model_beat(hv, 1'b0);
        n_checks++;
        if (bus.cmd_err !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reject_cmd_err: cmd_err=%b busy=%b out_valid=%b, required 1 0 0",
                               bus.cmd_err, bus.busy, bus.out_valid);
        end
        tick();
        n_checks++;
        if (bus.cmd_err !== 1'b0 || err_cnt - e0 != 1) begin
            n_fail++; $display("FAIL reject_pulse_width: cmd_err=%b pulses=%0d, required 0 1", bus.cmd_err, err_cnt - e0);
        end
        while (m_wr != 0) send_beat(DIMS'($urandom), 1'($urandom_range(0, 1)));
        readout(0);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || bus.hv_count !== 16'(m_hv)) begin
            n_fail++; $display("FAIL reject_then_read: beats=%0d bad_dims=%0d hv_count=%0d, required 16 0 %0d",
                               cap_n, model_diff(), bus.hv_count, m_hv);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_hv(DIMS'($urandom), 1'b0, 2);
        for (int c = 0; c < NCH; c++) send_beat(DIMS'($urandom), 1'($urandom_range(0, 1)));
        bus.in_valid = 1'b1;
        bus.in_hv    = '1;
        bus.in_sub   = 1'b0;
        readout(1);
        n_checks++;
        if (cap_n != NCH || cap_idx_bad || cap_hold_bad) begin
            n_fail++; $display("FAIL stall_hold: beats=%0d idx_bad=%b hold_bad=%b, required 16 0 0",
                               cap_n, cap_idx_bad, cap_hold_bad);
        end
        n_checks++;
        if (cap_rdy_bad || cap_end_valid) begin
            n_fail++; $display("FAIL stall_in_ready: in_ready_seen=%b end_valid=%b, required 0 0", cap_rdy_bad, cap_end_valid);
        end
        readout(2);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || last_bad() != 0) begin
            n_fail++; $display("FAIL stall_data: beats=%0d bad_dims=%0d bad_last=%0d, required 16 0 0",
                               cap_n, model_diff(), last_bad());
        end
    endtask

    task automatic test_random();
        int d0, e0;
        do_reset();
        d0 = done_cnt; e0 = exp_done;
        while (m_hv < 5) begin
            if ($urandom_range(0, 3) == 0) tick();
            else send_beat(DIMS'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        readout(2);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || cap_hold_bad || cap_idx_bad) begin
            n_fail++; $display("FAIL random_data: beats=%0d bad_dims=%0d hold_bad=%b idx_bad=%b, required 16 0 0 0",
                               cap_n, model_diff(), cap_hold_bad, cap_idx_bad);
        end
        n_checks++;
        if (bus.hv_count !== 16'd5 || done_cnt - d0 != exp_done - e0) begin
            n_fail++; $display("FAIL random_hv_count: hv_count=%0d pulses=%0d, required 5 %0d",
                               bus.hv_count, done_cnt - d0, exp_done - e0);
        end
    endtask

    task automatic test_clear_collision();
        int nbusy;
        do_reset();
        send_hv(DIMS'($urandom), 1'b0, 2);
        for (int b = 0; b < 5; b++) send_beat(DIMS'($urandom), 1'b0);
        bus.clear_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_hv       = '1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL clear_in_ready: got %b, required 0", bus.in_ready);
        end
        tick();
        bus.clear_start = 1'b0;
        bus.in_valid    = 1'b0;
        model_reset();
        nbusy = 0;
        while (bus.busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            tick();
        end
        n_checks++;
        if (nbusy != NCH || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_busy: busy_cycles=%0d in_ready=%b, required 16 1", nbusy, bus.in_ready);
        end
        readout(0);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || bus.hv_count !== 16'd0) begin
            n_fail++; $display("FAIL clear_data: beats=%0d bad_dims=%0d hv_count=%0d, required 16 0 0",
                               cap_n, model_diff(), bus.hv_count);
        end
    endtask

    task automatic test_reset_mid_readout();
        do_reset();
        send_hv('1, 1'b0, 1);
        bus.readout_start = 1'b1;
        tick();
        bus.readout_start = 1'b0;
        bus.out_ready     = 1'b1;
        for (int b = 0; b < 5; b++) tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'd5 || bus.out_data[0] !== 8'd1) begin
            n_fail++; $display("FAIL midrd_position: out_valid=%b out_idx=%0d d0=%0d, required 1 5 1",
                               bus.out_valid, bus.out_idx, bus.out_data[0]);
        end
        nrst = 1'b0;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== '0) begin
            n_fail++; $display("FAIL midrd_abort: out_valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
        end
        nrst = 1'b1;
        bus.out_ready = 1'b0;
        model_reset();
        readout(0);
        n_checks++;
        if (cap_n != NCH || model_diff() != 0 || bus.hv_count !== 16'd0) begin
            n_fail++; $display("FAIL midrd_zero: beats=%0d bad_dims=%0d hv_count=%0d, required 16 0 0",
                               cap_n, model_diff(), bus.hv_count);
        end
    endtask

    initial begin
        exp_done = 0;
        test_reset();
        test_bundle_ones();
        test_saturation();
        test_alternating();
        test_readout_reject();
        test_backpressure();
        test_random();
        test_clear_collision();
        test_reset_mid_readout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
